miss_req_queue: RTL

MISS_REQ_QUEUE -- requirements
Module: miss_req_queue

---
 rtl/cache_pkg.sv | 23 ++
 rtl/miss_fifo.sv | 97 +++++++++
 rtl/miss_req_queue.sv | 122 ++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the instruction-cache miss path.
// Holds the line-address width, the trace command codes driven by the
// trace player, and the state type of the miss request FSM.
package cache_pkg;

  // Line address is bits 31:6 of a byte address (64-byte lines).
  localparam int ADDR_W = 26;

  // Trace command codes; CMD_RESET is what drives the queue's clear input.
  localparam logic [3:0] CMD_INST_FETCH = 4'd2;
  localparam logic [3:0] CMD_INVALIDATE = 4'd3;
  localparam logic [3:0] CMD_RESET      = 4'd8;
  localparam logic [3:0] CMD_PRINT      = 4'd9;

  // Miss request FSM: IDLE (nothing outstanding), REQ (presenting the
  // request), WAIT (request accepted, awaiting the line).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } miss_state_e;

endpackage

// File: rtl/miss_fifo.sv
// Storage for pending miss line addresses, kept in arrival order.
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   clear        - synchronous flush of all entries and pointers (wins over push/pop)
//   push         - write push_addr at the tail
//   pop          - retire the head entry
//   push_addr    - address to write; also the operand of the parallel match
//   head_addr    - address stored at the head
//   hit          - push_addr equals some currently valid entry
//   count        - number of valid entries
module miss_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 26
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [ADDR_W-1:0]        push_addr,
  output logic [ADDR_W-1:0]        head_addr,
  output logic                     hit,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0]  addr_q [DEPTH];
  logic [ADDR_W-1:0]  addr_d [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;

  assign head_addr = addr_q[head_q];
  assign count     = count_q;

  // Match against registered entries only, so an entry popping this very
  // cycle still absorbs a duplicate miss.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i] == push_addr)) begin
        hit = 1'b1;
      end
    end
  end

  // Pointers are PTR_W bits wide, so increments wrap modulo DEPTH.
  always_comb begin
    addr_d  = addr_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear) begin
      valid_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      if (push) begin
        addr_d[tail_q]  = push_addr;
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      addr_q  <= addr_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/miss_req_queue.sv
// Instruction-cache miss request queue. Buffers miss line addresses,
// merges duplicates, and issues them one at a time to the next level.
// Ports:
//   clk, rst                   - clock, asynchronous active-high reset
//   clear                      - synchronous flush (trace RESET command)
//   miss_valid/miss_addr       - miss presented by the instruction cache
//   miss_ready                 - a miss is accepted when valid and ready
//   l2_req_valid/l2_req_addr   - read request to the next level
//   l2_req_ready               - next level takes the request
//   l2_resp_valid              - line returned for the outstanding request
//   issued, merged             - 32-bit wrapping event counters
//   occupancy                  - number of queued entries
module miss_req_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = cache_pkg::ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     miss_valid,
  input  logic [ADDR_W-1:0]        miss_addr,
  output logic                     miss_ready,
  output logic                     l2_req_valid,
  output logic [ADDR_W-1:0]        l2_req_addr,
  input  logic                     l2_req_ready,
  input  logic                     l2_resp_valid,
  output logic [31:0]              issued,
  output logic [31:0]              merged,
  output logic [$clog2(DEPTH):0]   occupancy
);

  import cache_pkg::*;

  miss_state_e          state_q, state_d;
  logic [31:0]          issued_q, issued_d;
  logic [31:0]          merged_q, merged_d;
  logic                 accept;
  logic                 push;
  logic                 pop;
  logic                 hit;
  logic [ADDR_W-1:0]    head_addr;

  miss_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_addr (miss_addr),
    .head_addr (head_addr),
    .hit       (hit),
    .count     (occupancy)
  );

  // Readiness comes from registered occupancy only; a pop in the same
  // cycle does not make room for a push.
  assign miss_ready   = (occupancy < ($clog2(DEPTH) + 1)'(DEPTH));
  assign accept       = miss_valid && miss_ready;
  assign l2_req_valid = (state_q == REQ);
  assign l2_req_addr  = l2_req_valid ? head_addr : '0;
  assign issued       = issued_q;
  assign merged       = merged_q;

  // Next state, counters and queue control. clear overrides everything,
  // including a response, so a flushed request can never pop an entry.
  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    merged_d = merged_q;
    push     = 1'b0;
    pop      = 1'b0;
    if (clear) begin
      state_d  = IDLE;
      issued_d = '0;
      merged_d = '0;
    end else begin
      if (accept) begin
        if (hit) begin
          merged_d = merged_q + 32'd1;
        end else begin
          push = 1'b1;
        end
      end
      unique case (state_q)
        IDLE: begin
          if (occupancy != '0) begin
            state_d = REQ;
          end
        end
        REQ: begin
          if (l2_req_ready) begin
            state_d  = WAIT;
            issued_d = issued_q + 32'd1;
          end
        end
        WAIT: begin
          if (l2_resp_valid) begin
            state_d = IDLE;
            pop     = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      issued_q <= '0;
      merged_q <= '0;
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      merged_q <= merged_d;
    end
  end

endmodule
